// File: rtl/sw_target_feeder.sv
// Head-of-array feeder for the Smith-Waterman PE chain: buffers one target, then emits
// marker, contiguous base stream and drain bubbles on the first PE's t/v/f/max inputs.
module sw_target_feeder #(
  parameter int CALC_BIT = 16,
  parameter int MAX_LEN  = 256,
  parameter int N_PE     = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_base,
  input  logic                in_last,
  output logic [2:0]          t_o,
  output logic [CALC_BIT-1:0] v_o,
  output logic [CALC_BIT-1:0] f_o,
  output logic [CALC_BIT-1:0] max_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(2 * N_PE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_MARK   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [LW-1:0] LEN_FULL   = LW'(MAX_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N_PE - 1);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [2:0]    t_q, t_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic          accept;
  logic [1:0]    buf_q [MAX_LEN];

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign t_o        = t_q;
  assign v_o        = '0;
  assign f_o        = '0;
  assign max_o      = '0;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    dcnt_d  = dcnt_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_idx  = len_q[AW-1:0];
    case (state_q)
      S_IDLE: if (accept) begin
        wr_en   = 1'b1;
        wr_idx  = '0;
        len_d   = LW'(1);
        ovf_d   = 1'b0;
        state_d = in_last ? S_MARK : S_LOAD;
      end
      S_LOAD: if (accept) begin
        wr_en = 1'b1;
        len_d = len_q + LW'(1);
        if (in_last) begin
          state_d = S_MARK;
        end else if (len_q == LEN_FULL) begin
          // Buffer full without in_last: close the target here, later beats wait upstream.
          ovf_d   = 1'b1;
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        rd_d    = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_q == len_q - LW'(1)) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          rd_d = rd_q + LW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) state_d = S_IDLE;
        else                      dcnt_d  = dcnt_q + DW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with the registered state.
  always_comb begin
    t_d = 3'b000;
    case (state_d)
      S_MARK:   t_d = 3'b001;
      S_STREAM: t_d = {1'b1, buf_q[rd_d[AW-1:0]]};
      default:  t_d = 3'b000;
    endcase
    done_d = (state_d == S_DRAIN) && (dcnt_d == DRAIN_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      rd_q    <= '0;
      dcnt_q  <= '0;
      t_q     <= 3'b000;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      dcnt_q  <= dcnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= in_base;
  end

endmodule
